// File: rtl/rr_sel_pkg.sv
// -----------------------------------------------------------------------------
// rr_sel_pkg
// -----------------------------------------------------------------------------
// Shared definitions for the round-robin select arbiter.
//   NUM_CH       : number of arbitrated channels (fixed at 4)
//   sel_t        : 2-bit mux select / channel index
//   gnt_t        : 4-bit one-hot grant vector
//   arb_state_t  : arbiter FSM state (IDLE, GRANT)
//   sel_to_gnt() : converts a channel index into its one-hot grant
// -----------------------------------------------------------------------------
package rr_sel_pkg;

   localparam int NUM_CH = 4;

   typedef logic [1:0] sel_t;
   typedef logic [3:0] gnt_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // One-hot grant for a channel index.
   function automatic gnt_t sel_to_gnt(input sel_t sel);
      gnt_t one;
      one = 4'b0001;
      return one << sel;
   endfunction

endpackage : rr_sel_pkg

// File: rtl/rr_prio_pick.sv
// -----------------------------------------------------------------------------
// rr_prio_pick
// -----------------------------------------------------------------------------
// Purely combinational rotate-and-priority search. Starting just after the
// last-granted channel (ptr), channels are examined in the order
// ptr+1, ptr+2, ptr+3, ptr (mod 4); the first requester wins. Checking ptr
// itself last lets a lone requester be re-granted back-to-back.
//
// Ports
//   req  in  [3:0]  per-channel request vector
//   ptr  in  [1:0]  last-granted channel (search starts at ptr+1)
//   any  out        at least one request is present
//   sel  out [1:0]  chosen channel (equals ptr when any=0, don't care)
// -----------------------------------------------------------------------------
import rr_sel_pkg::*;

module rr_prio_pick (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       any,
   output logic [1:0] sel
);

   // cand[gi] is the channel examined at search position gi (0 = highest
   // priority); rot[gi] is that channel's request, i.e. req rotated by ptr+1.
   sel_t cand [NUM_CH];
   logic [NUM_CH-1:0] rot;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
      assign cand[gi] = ptr + sel_t'(gi + 1);
      assign rot[gi]  = req[cand[gi]];
   end

   assign any = |req;

   // Walk from lowest priority to highest so the highest-priority requester
   // is the last (and therefore winning) assignment.
   always_comb begin
      sel = ptr;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sel = cand[k];
         end
      end
   end

endmodule : rr_prio_pick

// File: rtl/rr_sel_arbiter.sv
// -----------------------------------------------------------------------------
// rr_sel_arbiter
// -----------------------------------------------------------------------------
// Four-channel round-robin arbiter that drives the select of a downstream
// 4-to-1 mux. A grant is issued one cycle after a request is sampled and is
// held (s, gnt, valid all stable) until the consumer handshakes with
// valid && ready. On a handshake the next grant is issued on the following
// edge with no idle bubble if anyone is still requesting; otherwise the
// arbiter returns to IDLE. Dropping the granted request mid-grant does not
// cancel it: a grant only ends by handshake (or reset).
//
// Parameters
//   IDLE_SEL        select value presented while no grant is active
//
// Ports
//   clk    in         single clock, rising edge
//   rst    in         synchronous active-high reset (drops any in-flight grant)
//   req    in  [3:0]  per-channel request
//   ready  in         consumer accepts the selected channel (ignored if !valid)
//   s      out [1:0]  registered mux select
//   gnt    out [3:0]  registered one-hot grant, gnt == 1<<s while valid
//   valid  out        registered, a grant is active
//
// Build option
//   RR_SEL_ARBITER_ASSERT_EN : when defined, embedded concurrent assertions
//   are compiled (one-hot grant, grant/select consistency, hold under
//   backpressure, bounded wait). Behaviour is identical either way.
// -----------------------------------------------------------------------------
import rr_sel_pkg::*;

module rr_sel_arbiter #(
   parameter sel_t IDLE_SEL = 2'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       ready,
   output logic [1:0] s,
   output logic [3:0] gnt,
   output logic       valid
);

   arb_state_t state_q;
   sel_t       ptr_q;     // last channel that completed a handshake
   sel_t       s_q;
   gnt_t       gnt_q;
   logic       valid_q;

   sel_t       pick_ptr_d;
   logic       pick_any_d;
   sel_t       pick_sel_d;
   logic       handshake_d;

   assign handshake_d = valid_q && ready;

   // During a grant the search must start after the channel being granted,
   // which becomes the new pointer on the handshake edge. Feeding s_q
   // directly avoids waiting a cycle for ptr_q to update.
   assign pick_ptr_d = (state_q == GRANT) ? s_q : ptr_q;

   rr_prio_pick u_pick (
      .req (req),
      .ptr (pick_ptr_d),
      .any (pick_any_d),
      .sel (pick_sel_d)
   );

   // Single-process FSM; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd3;          // ch0 gets first priority out of reset
         s_q     <= IDLE_SEL;
         gnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any_d) begin
                  state_q <= GRANT;
                  s_q     <= pick_sel_d;
                  gnt_q   <= sel_to_gnt(pick_sel_d);
                  valid_q <= 1'b1;
               end
            end
            GRANT: begin
               if (handshake_d) begin
                  ptr_q <= s_q;
                  if (pick_any_d) begin
                     // Back-to-back grant, possibly to the same channel.
                     s_q   <= pick_sel_d;
                     gnt_q <= sel_to_gnt(pick_sel_d);
                  end else begin
                     state_q <= IDLE;
                     s_q     <= IDLE_SEL;
                     gnt_q   <= '0;
                     valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               s_q     <= IDLE_SEL;
               gnt_q   <= '0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // The select goes straight to the downstream mux.
   assign s     = s_q;
   assign gnt   = gnt_q;
   assign valid = valid_q;

`ifdef RR_SEL_ARBITER_ASSERT_EN
   // ---------------------------------------------------------------------
   // Embedded checks
   // ---------------------------------------------------------------------
   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(gnt_q));

   a_gnt_matches_s : assert property (@(posedge clk) disable iff (rst)
      valid_q |-> (gnt_q == sel_to_gnt(s_q)));

   a_idle_outputs : assert property (@(posedge clk) disable iff (rst)
      !valid_q |-> (gnt_q == '0 && s_q == IDLE_SEL));

   a_hold_on_stall : assert property (@(posedge clk) disable iff (rst)
      (valid_q && !ready) |=> (valid_q && $stable(s_q) && $stable(gnt_q)));

   // Count handshakes to other channels while a request is held. With the
   // rotating search a held request can be passed over by at most three
   // other handshakes, so it is served no later than the fourth.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fair
      logic [2:0] wait_cnt_q;

      always_ff @(posedge clk) begin
         if (rst || !req[gi]) begin
            wait_cnt_q <= '0;
         end else if (handshake_d && (s_q == sel_t'(gi))) begin
            wait_cnt_q <= '0;
         end else if (handshake_d && (wait_cnt_q != 3'd7)) begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
         end
      end

      a_fair : assert property (@(posedge clk) disable iff (rst)
         wait_cnt_q <= 3'd3);
   end
`endif

endmodule : rr_sel_arbiter

// File: tb/tb_rr_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_sel_arbiter
// -----------------------------------------------------------------------------
// Directed scoreboard bench. Each stimulus step drives rst/req/ready shortly
// after a rising edge and pushes the hand-computed outputs expected after the
// next rising edge; an independent monitor pops one expectation per cycle,
// 1 time unit after the edge, and compares valid/s/gnt.
// A non-zero IDLE_SEL is used so the idle select value is observable.
// -----------------------------------------------------------------------------
import rr_sel_pkg::*;

module tb_rr_sel_arbiter;

   localparam sel_t TB_IDLE_SEL = 2'd2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       ready;
   logic [1:0] s;
   logic [3:0] gnt;
   logic       valid;

   always #5 clk = ~clk;

   rr_sel_arbiter #(.IDLE_SEL(TB_IDLE_SEL)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .ready (ready),
      .s     (s),
      .gnt   (gnt),
      .valid (valid)
   );

   typedef struct {
      logic       v;
      logic [1:0] s;
      logic [3:0] g;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Drive one cycle of inputs and queue the outputs expected after the
   // edge that samples them. gnt is given explicitly so the bench does not
   // rely on the DUT's own encoding.
   task automatic cyc(input logic r, input logic [3:0] rq, input logic rdy,
                      input logic ev, input logic [1:0] es,
                      input logic [3:0] eg, input string name);
      exp_t e;
      @(posedge clk);
      #2;
      rst   = r;
      req   = rq;
      ready = rdy;
      e.v    = ev;
      e.s    = ev ? es : TB_IDLE_SEL;
      e.g    = eg;
      e.name = name;
      sb_q.push_back(e);
   endtask

   // Monitor: one comparison per queued expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (valid !== mon_e.v || s !== mon_e.s || gnt !== mon_e.g) begin
               errors++;
               $display("FAIL %s: got valid=%0b s=%0d gnt=%b, expected valid=%0b s=%0d gnt=%b",
                        mon_e.name, valid, s, gnt, mon_e.v, mon_e.s, mon_e.g);
            end else begin
               $display("ok   %s: valid=%0b s=%0d gnt=%b", mon_e.name, valid, s, gnt);
            end
         end
      end
   end

   initial begin
      rst   = 1'b1;
      req   = 4'b0000;
      ready = 1'b0;

      // Reset held two cycles with all channels requesting.
      cyc(1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, "rst_cycle1");
      cyc(1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, "rst_cycle2");
      cyc(1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001, "first_grant_ch0");

      // Rotation with ready held high: 0 -> 1 -> 2 -> 3 -> 0.
      cyc(1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, "rot_ch1");
      cyc(1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, "rot_ch2");
      cyc(1'b0, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, "rot_ch3");
      cyc(1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, "rot_wrap_ch0");
      cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, "rot_to_idle");

      // Backpressure on ch2: six cycles of stable grant, then idle.
      cyc(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, "bp_grant_ch2");
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, "bp_hold");
      end
      cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, "bp_release");

      // Request withdrawal: grant to ch1 survives req[1] dropping.
      cyc(1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, "wd_grant_ch1");
      cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, "wd_hold_no_req");
      cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, "wd_done_idle");

      // ready while idle has no effect.
      cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, "idle_ready_ignored");

      // ch3 granted, lone requester re-granted, then wrap/skip on 1010.
      cyc(1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, "wrap_grant_ch3");
      cyc(1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, "regrant_ch3");
      cyc(1'b0, 4'b1010, 1'b1, 1'b1, 2'd1, 4'b0010, "wrap_skip_ch1");
      cyc(1'b0, 4'b1010, 1'b1, 1'b1, 2'd3, 4'b1000, "wrap_skip_ch3");
      cyc(1'b0, 4'b0101, 1'b1, 1'b1, 2'd0, 4'b0001, "skip_to_ch0");
      cyc(1'b0, 4'b0101, 1'b1, 1'b1, 2'd2, 4'b0100, "skip_to_ch2");
      cyc(1'b0, 4'b0101, 1'b0, 1'b1, 2'd2, 4'b0100, "stall_ch2");

      // Reset during a stalled grant drops it.
      cyc(1'b1, 4'b0101, 1'b0, 1'b0, 2'd0, 4'b0000, "mid_rst");
      cyc(1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, "post_rst_ch3");
      cyc(1'b0, 4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001, "post_rst_next_ch0");
      cyc(1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 4'b0010, "post_rst_next_ch1");
      cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, "final_idle");

      repeat (3) @(posedge clk);
      #3;
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rr_sel_arbiter

// File: doc/rr_sel_arbiter.md
RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 SHALL have parameter: IDLE_SEL, 2'd0, select value driven while no grant is active.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: req  input  4  per-channel request, bit i = channel i.
REQ-005 SHALL have port: ready  input  1  downstream consumer accepts the currently selected channel.
REQ-006 SHALL have port: s  output  2  registered mux select for the downstream 4-to-1 mux.
REQ-007 SHALL have port: gnt  output  4  registered one-hot grant, bit index equals s while valid.
REQ-008 SHALL have port: valid  output  1  registered; a grant is active and s is meaningful.

Function
REQ-009 SHALL implement FSM states IDLE and GRANT, plus a 2-bit last-grant pointer ptr.
REQ-010 SHALL in IDLE drive valid=0, gnt=4'b0000, s=IDLE_SEL.
REQ-011 SHALL in IDLE with req!=0 select the first requesting channel searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-012 SHALL register that choice into s/gnt and set valid=1 one cycle after req is sampled; this is 1-cycle latency.
REQ-013 SHALL in GRANT hold s, gnt and valid stable until the handshake valid&&ready occurs.
REQ-014 SHALL ignore deassertion of the granted req bit in GRANT; the grant completes only by handshake.
REQ-015 SHALL on a handshake update ptr to the granted channel in the same edge.
REQ-016 SHALL on a handshake with any other req bit set issue the next grant on the following edge, searching from the granted channel+1, with no idle bubble.
REQ-017 SHALL on a handshake where only the just-granted channel still requests re-grant that channel back-to-back.
REQ-018 SHALL on a handshake with req==0 return to IDLE; valid=0 on the next cycle.
REQ-019 SHALL ignore ready while valid=0.
REQ-020 SHALL never assert more than one gnt bit, and SHALL keep gnt==(4'b0001<<s) whenever valid=1.
REQ-021 SHALL wrap the pointer modulo 4; after ch3 is granted, ch0 has highest priority.

Reset
REQ-022 SHALL on rst=1 at a clock edge force state=IDLE, valid=0, gnt=0, s=IDLE_SEL and ptr=2'd3, so ch0 has first priority.
REQ-023 SHALL let rst override an in-flight grant; the transaction is dropped and no handshake is reported.
REQ-024 SHALL evaluate the first arbitration on the first edge with rst=0.

Configuration
REQ-025 SHALL compile embedded concurrent assertions only when RR_SEL_ARBITER_ASSERT_EN is defined.
REQ-026 SHALL when RR_SEL_ARBITER_ASSERT_EN is defined check: gnt one-hot-or-zero, gnt/s consistency, s/gnt stable while valid&&!ready, and that every req held high is granted within 4 handshakes.
REQ-027 SHALL when RR_SEL_ARBITER_ASSERT_EN is undefined contain no assertion code; functional behaviour is identical.

Structure
REQ-028 SHALL take from shared package rr_sel_pkg: localparam NUM_CH=4, typedef sel_t (logic [1:0]), typedef gnt_t (logic [3:0]), typedef enum arb_state_t {IDLE, GRANT}.
REQ-029 SHALL place the rotate-and-priority search in combinational sub-module rr_prio_pick (inputs req, ptr; outputs any, sel).
REQ-030 SHALL connect s directly to the downstream mux select with no extra logic.

Verification
REQ-031 SHALL check reset: rst high 2 cycles, req=4'b1111 -> valid=0, gnt=0, s=IDLE_SEL during reset; then gnt=0001, s=0 one cycle after rst falls.
REQ-032 SHALL check rotation: req=1111, ready=1 constant -> s sequence 0,1,2,3,0 on consecutive cycles with valid=1 throughout.
REQ-033 SHALL check backpressure: req=0100, ready=0 for 5 cycles then 1 -> s=2, gnt=0100 stable for 6 cycles, then valid=0.
REQ-034 SHALL check req withdrawal: grant ch1, drop req[1] while ready=0, then ready=1 -> handshake completes on ch1, next state IDLE.
REQ-035 SHALL check wrap/skip: ptr=3 after a ch3 grant, req=1010 -> next s=1, then s=3.
REQ-036 SHALL check mid-operation reset: rst pulsed while valid=1 and ready=0 -> valid=0 next cycle; post-reset req=1000 -> s=3 one cycle later.
